// File: rtl/usb_rx_bit_decoder.sv
// USB receive front end: SYNC detection, NRZI decode, bit de-stuffing and EOP detection.
// Optional macro USB_RX_STUFF_CHECK_EN turns a stuffed-bit position that decodes to 1 into a packet error.
module usb_rx_bit_decoder #(
  parameter int MAX_BITS = 96
) (
  input  logic clock,
  input  logic reset,
  input  logic rx_enable,
  input  logic DP_in,
  input  logic DM_in,
  output logic bit_out,
  output logic bit_valid,
  output logic pkt_start,
  output logic pkt_end,
  output logic rx_error,
  output logic rx_busy
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SYNC = 2'd1,
    ST_RECV = 2'd2,
    ST_EOP  = 2'd3
  } state_e;

  localparam logic [1:0] SYM_SE0 = 2'b00;
  localparam logic [1:0] SYM_K   = 2'b01;
  localparam logic [1:0] SYM_J   = 2'b10;
  localparam logic [1:0] SYM_SE1 = 2'b11;

  localparam int CNT_W = $clog2(MAX_BITS + 1);
  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_BITS);

  state_e           state_q, state_d;
  logic [1:0]       prev_sym_q, prev_sym_d;
  logic [2:0]       sync_cnt_q, sync_cnt_d;
  logic [2:0]       ones_cnt_q, ones_cnt_d;
  logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d;
  logic [1:0]       eop_cnt_q, eop_cnt_d;

  logic bit_out_q, bit_out_d;
  logic bit_valid_q, bit_valid_d;
  logic pkt_start_q, pkt_start_d;
  logic pkt_end_q, pkt_end_d;
  logic rx_error_q, rx_error_d;
  logic rx_busy_q, rx_busy_d;

  logic [1:0] sym;
  logic [1:0] sync_exp;
  logic       raw;
  logic       sym_jk;
  logic       stuff_pos;
  logic       at_limit;
  logic       eop_ok;

  assign sym       = {DP_in, DM_in};
  assign raw       = (sym == prev_sym_q);
  assign sym_jk    = (sym == SYM_J) || (sym == SYM_K);
  assign stuff_pos = (ones_cnt_q == 3'd6);
  assign at_limit  = (bit_cnt_q == MAX_CNT);
  assign eop_ok    = (bit_cnt_q[2:0] == 3'd0) && (bit_cnt_q != '0);
  // SYNC is K J K J K J K K: odd positions are J except the final one.
  assign sync_exp  = ((sync_cnt_q == 3'd7) || !sync_cnt_q[0]) ? SYM_K : SYM_J;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      prev_sym_q  <= SYM_J;
      sync_cnt_q  <= '0;
      ones_cnt_q  <= '0;
      bit_cnt_q   <= '0;
      eop_cnt_q   <= '0;
      bit_out_q   <= 1'b0;
      bit_valid_q <= 1'b0;
      pkt_start_q <= 1'b0;
      pkt_end_q   <= 1'b0;
      rx_error_q  <= 1'b0;
      rx_busy_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      prev_sym_q  <= prev_sym_d;
      sync_cnt_q  <= sync_cnt_d;
      ones_cnt_q  <= ones_cnt_d;
      bit_cnt_q   <= bit_cnt_d;
      eop_cnt_q   <= eop_cnt_d;
      bit_out_q   <= bit_out_d;
      bit_valid_q <= bit_valid_d;
      pkt_start_q <= pkt_start_d;
      pkt_end_q   <= pkt_end_d;
      rx_error_q  <= rx_error_d;
      rx_busy_q   <= rx_busy_d;
    end
  end

  // Strobe decode; the next-state logic below keys its exits off these.
  always_comb begin
    bit_valid_d = 1'b0;
    pkt_start_d = 1'b0;
    pkt_end_d   = 1'b0;
    rx_error_d  = 1'b0;
    if (rx_enable) begin
      case (state_q)
        ST_SYNC: begin
          pkt_start_d = (sym == sync_exp) && (sync_cnt_q == 3'd7);
        end
        ST_RECV: begin
          if (sym_jk) begin
            if (stuff_pos) begin
`ifdef USB_RX_STUFF_CHECK_EN
              rx_error_d = raw;
`endif
            end else if (at_limit) begin
              rx_error_d = 1'b1;
            end else begin
              bit_valid_d = 1'b1;
            end
          end else if (sym == SYM_SE1) begin
            rx_error_d = 1'b1;
          end
        end
        ST_EOP: begin
          if ((eop_cnt_q == 2'd2) && (sym == SYM_J)) begin
            pkt_end_d  = eop_ok;
            rx_error_d = !eop_ok;
          end else if (!((eop_cnt_q == 2'd1) && (sym == SYM_SE0))) begin
            rx_error_d = 1'b1;
          end
        end
        default: ;
      endcase
    end
    bit_out_d = bit_valid_d & raw;
    rx_busy_d = (state_d != ST_IDLE);
  end

  always_comb begin
    state_d    = state_q;
    prev_sym_d = prev_sym_q;
    sync_cnt_d = sync_cnt_q;
    ones_cnt_d = ones_cnt_q;
    bit_cnt_d  = bit_cnt_q;
    eop_cnt_d  = eop_cnt_q;
    if (!rx_enable) begin
      state_d    = ST_IDLE;
      prev_sym_d = SYM_J;
      sync_cnt_d = '0;
      ones_cnt_d = '0;
      bit_cnt_d  = '0;
      eop_cnt_d  = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          prev_sym_d = sym;
          if ((prev_sym_q == SYM_J) && (sym == SYM_K)) begin
            state_d    = ST_SYNC;
            sync_cnt_d = 3'd1;
          end
        end
        ST_SYNC: begin
          prev_sym_d = sym;
          if (sym != sync_exp) begin
            state_d = ST_IDLE;
          end else if (sync_cnt_q == 3'd7) begin
            state_d    = ST_RECV;
            prev_sym_d = SYM_K;
            ones_cnt_d = '0;
            bit_cnt_d  = '0;
          end else begin
            sync_cnt_d = sync_cnt_q + 3'd1;
          end
        end
        ST_RECV: begin
          prev_sym_d = sym;
          if (rx_error_d) begin
            state_d = ST_IDLE;
          end else if (sym_jk) begin
            if (stuff_pos) begin
              ones_cnt_d = '0;
            end else begin
              bit_cnt_d  = bit_cnt_q + 1'b1;
              ones_cnt_d = raw ? ones_cnt_q + 3'd1 : 3'd0;
            end
          end else begin
            state_d   = ST_EOP;
            eop_cnt_d = 2'd1;
          end
        end
        ST_EOP: begin
          // The closing J lands in prev_sym so a back-to-back SYNC is seen.
          prev_sym_d = sym;
          if (rx_error_d || pkt_end_d) begin
            state_d = ST_IDLE;
          end else begin
            eop_cnt_d = 2'd2;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  assign bit_out   = bit_out_q;
  assign bit_valid = bit_valid_q;
  assign pkt_start = pkt_start_q;
  assign pkt_end   = pkt_end_q;
  assign rx_error  = rx_error_q;
  assign rx_busy   = rx_busy_q;

endmodule

// File: tb/tb_usb_rx_bit_decoder.sv
// Directed bench for usb_rx_bit_decoder: drives bus symbols and checks decoded bits and strobes.
module tb_usb_rx_bit_decoder;

  localparam logic [1:0] SE0 = 2'b00;
  localparam logic [1:0] K   = 2'b01;
  localparam logic [1:0] J   = 2'b10;

  logic clock = 1'b0;
  logic reset, rx_enable, DP_in, DM_in;
  logic bit_out, bit_valid, pkt_start, pkt_end, rx_error, rx_busy;

  usb_rx_bit_decoder #(.MAX_BITS(96)) dut (
    .clock(clock), .reset(reset), .rx_enable(rx_enable),
    .DP_in(DP_in), .DM_in(DM_in),
    .bit_out(bit_out), .bit_valid(bit_valid), .pkt_start(pkt_start),
    .pkt_end(pkt_end), .rx_error(rx_error), .rx_busy(rx_busy)
  );

  always #5 clock = ~clock;

  int errors = 0;
  int checks = 0;
  int nbits, starts, ends, errs;
  logic [127:0] cap;
  logic [1:0]   tx_lvl;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_counts();
    nbits = 0; starts = 0; ends = 0; errs = 0; cap = '0;
  endtask

  task automatic tick(input logic [1:0] s);
    @(negedge clock);
    {DP_in, DM_in} = s;
    @(posedge clock);
    #1;
    if (bit_valid === 1'b1) begin
      if (nbits < 128) cap[nbits] = bit_out;
      nbits++;
    end
    if (pkt_start === 1'b1) starts++;
    if (pkt_end === 1'b1) ends++;
    if (rx_error === 1'b1) errs++;
    $display("sym=%b valid=%b bit=%b start=%b end=%b err=%b busy=%b",
             s, bit_valid, bit_out, pkt_start, pkt_end, rx_error, rx_busy);
  endtask

  task automatic send_sync();
    tick(K); tick(J); tick(K); tick(J); tick(K); tick(J); tick(K); tick(K);
    tx_lvl = K;
  endtask

  // NRZI: a 0 toggles the line, a 1 holds it. Stuffed bits are written into v by hand.
  task automatic send_bits(input logic [31:0] v, input int n);
    for (int i = 0; i < n; i++) begin
      if (!v[i]) tx_lvl = (tx_lvl == J) ? K : J;
      tick(tx_lvl);
    end
  endtask

  task automatic send_eop();
    tick(SE0); tick(SE0); tick(J);
  endtask

  initial begin
    reset = 1'b1; rx_enable = 1'b1; {DP_in, DM_in} = J; tx_lvl = J;
    clear_counts();
    tick(J); tick(J);
    chk("reset_outputs", {26'd0, bit_out, bit_valid, pkt_start, pkt_end, rx_error, rx_busy}, 32'd0);
    reset = 1'b0;

    // 1: single byte 0xE1
    clear_counts();
    tick(J); tick(J); tick(J);
    send_sync();
    chk("t1_pkt_start", pkt_start, 1);
    chk("t1_busy", rx_busy, 1);
    send_bits(32'hE1, 8);
    tick(SE0); tick(SE0);
    chk("t1_no_early_end", pkt_end, 0);
    tick(J);
    chk("t1_pkt_end", pkt_end, 1);
    chk("t1_busy_low", rx_busy, 0);
    chk("t1_nbits", nbits, 8);
    chk("t1_data", cap[31:0], 32'hE1);
    chk("t1_starts", starts, 1);
    chk("t1_errs", errs, 0);

    // 2: back-to-back packet, 0xC3 0xFF with a hand-inserted stuffed 0 at raw bit 12
    clear_counts();
    send_sync();
    send_bits(32'h0001_EFC3, 17);
    send_eop();
    chk("t2_pkt_end", pkt_end, 1);
    chk("t2_nbits", nbits, 16);
    chk("t2_data", cap[31:0], 32'hFFC3);
    chk("t2_errs", errs, 0);

    // 3: seven consecutive ones
    clear_counts();
    tick(J);
    send_sync();
    send_bits(32'h7F, 7);
`ifdef USB_RX_STUFF_CHECK_EN
    chk("t3_stuff_err", rx_error, 1);
    chk("t3_busy_low", rx_busy, 0);
    tick(J); tick(J);
    chk("t3_ends", ends, 0);
    chk("t3_nbits", nbits, 6);
`else
    chk("t3_no_err", rx_error, 0);
    chk("t3_stuff_dropped", nbits, 6);
    send_bits(32'h0, 2);
    send_eop();
    chk("t3_pkt_end", pkt_end, 1);
    chk("t3_data", cap[31:0], 32'h3F);
    chk("t3_errs", errs, 0);
`endif

    // 4: 12 bits is not byte aligned
    clear_counts();
    tick(J);
    send_sync();
    send_bits(32'h5A3, 12);
    send_eop();
    chk("t4_rx_error", rx_error, 1);
    chk("t4_nbits", nbits, 12);
    chk("t4_data", cap[31:0], 32'h5A3);
    chk("t4_ends", ends, 0);

    // 5: bad SYNC then a good packet
    clear_counts();
    tick(J);
    tick(K); tick(J); tick(K); tick(J); tick(K); tick(K); tick(K); tick(K);
    chk("t5_bad_sync_start", starts, 0);
    chk("t5_bad_sync_idle", rx_busy, 0);
    tick(J);
    send_sync();
    send_bits(32'hE1, 8);
    send_eop();
    chk("t5_pkt_end", pkt_end, 1);
    chk("t5_data", cap[31:0], 32'hE1);
    chk("t5_starts", starts, 1);

    // 6: reset mid-packet aborts silently
    clear_counts();
    tick(J);
    send_sync();
    send_bits(32'h0D, 5);
    reset = 1'b1;
    tick(K);
    chk("t6_reset_outputs", {26'd0, bit_out, bit_valid, pkt_start, pkt_end, rx_error, rx_busy}, 32'd0);
    reset = 1'b0;
    tick(J); tick(J);
    chk("t6_no_strobe", ends + errs, 0);
    clear_counts();
    send_sync();
    send_bits(32'hE1, 8);
    send_eop();
    chk("t6_pkt_end", pkt_end, 1);
    chk("t6_nbits", nbits, 8);

    // rx_enable low holds IDLE
    rx_enable = 1'b0;
    tick(J); tick(K);
    chk("en_low_idle", rx_busy, 0);
    rx_enable = 1'b1;
    tick(J); tick(J);

    // MAX_BITS boundary: 96 bits accepted, the 97th aborts
    clear_counts();
    send_sync();
    for (int i = 0; i < 96; i++) send_bits(32'h0, 1);
    chk("max_nbits", nbits, 96);
    chk("max_no_err", errs, 0);
    chk("max_busy", rx_busy, 1);
    send_bits(32'h0, 1);
    chk("over_error", rx_error, 1);
    chk("over_no_valid", bit_valid, 0);
    chk("over_busy_low", rx_busy, 0);
    tick(J);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/usb_rx_bit_decoder.md
Name: usb_rx_bit_decoder

Overview:
- Bus-side receive front end. Consumes the DP/DM symbol stream that the packet sender drives onto USBWires, one symbol per clock.
- Detects SYNC, NRZI-decodes, removes stuffed bits, and detects EOP.
- Emits a clean serial bit stream, LSB-first as transmitted, with packet start/end/error strobes, for the downstream packet/PID/CRC parser.
- Used on the device-model side of the bench and, later, on the host receive path for handshakes and IN data.

Parameters:
- MAX_BITS, 96, maximum de-stuffed bits per packet (PID + 64-bit payload + CRC16 = 88, plus margin); exceeding it is an error.

Ports:
- clock  input  1  system clock; one bus symbol per cycle
- reset  input  1  synchronous, active-high reset
- rx_enable  input  1  0 forces and holds IDLE
- DP_in  input  1  bus D+ sample
- DM_in  input  1  bus D- sample
- bit_out  output  1  decoded, de-stuffed data bit
- bit_valid  output  1  bit_out is valid this cycle
- pkt_start  output  1  one-cycle pulse: SYNC accepted
- pkt_end  output  1  one-cycle pulse: good EOP, byte-aligned
- rx_error  output  1  one-cycle pulse: packet aborted
- rx_busy  output  1  state is not IDLE

Behaviour:
- Symbols: J = {DP,DM} = 10, K = 01, SE0 = 00, SE1 = 11.
- All outputs are registered and reflect the symbol sampled at the same edge (1-cycle latency). All outputs reset to 0.
- Reset or rx_enable = 0: state = IDLE, prev_sym = J, counters = 0.
- Reset mid-packet aborts silently: no pkt_end and no rx_error.

State machine:
- IDLE
  - Leave only on a J->K transition (the previous sampled symbol was J and the current one is K): go to SYNC with sync_cnt = 1.
  - All other symbols are ignored.
- SYNC
  - Compare each symbol with the pattern K J K J K J K K.
  - Any mismatch: go to IDLE with no strobe.
  - On the 8th symbol (K) matching: pulse pkt_start, set prev_sym = K, ones_cnt = 0, bit_cnt = 0, go to RECV.
- RECV, J or K symbol
  - NRZI decode: raw = 1 if sym == prev_sym, else 0. Then prev_sym <= sym.
  - If ones_cnt == 6, the bit is a stuffed bit: do not emit it, set ones_cnt = 0 (see the Optional Feature for raw = 1).
  - Otherwise: assert bit_valid with bit_out = raw, increment bit_cnt, ones_cnt = raw ? ones_cnt+1 : 0.
  - If bit_cnt would exceed MAX_BITS: pulse rx_error, go to IDLE.
- RECV, SE0: go to EOP with eop_cnt = 1. No bit is emitted.
- RECV, SE1: pulse rx_error, go to IDLE.
- EOP
  - Requires exactly SE0 then J.
  - Second SE0: eop_cnt = 2.
  - J after two SE0s: if bit_cnt mod 8 == 0 and bit_cnt > 0, pulse pkt_end; otherwise pulse rx_error. Go to IDLE in both cases.
  - Any other sequence (J after one SE0, a third SE0, K, SE1): pulse rx_error, go to IDLE.
- The J that ends the EOP counts as prev_sym = J for IDLE, so back-to-back packets separated by one J idle are accepted.
- pkt_start, pkt_end and rx_error are mutually exclusive in any cycle. bit_valid is never asserted outside RECV.

Optional Feature:
- Macro: USB_RX_STUFF_CHECK_EN.
- Defined: a stuffed-bit position that decodes to raw = 1 (seven consecutive ones) pulses rx_error, with no bit_valid, and returns to IDLE.
- Undefined: the stuffed-bit position is always dropped regardless of its value, and reception continues.

Test Plan:
1. J x3, SYNC, NRZI of byte 0xE1 (bits 1,0,0,0,0,1,1,1), SE0, SE0, J -> pkt_start once; 8 bit_valid pulses with that sequence; pkt_end one cycle after the final J is sampled; rx_error never asserted.
2. SYNC, then bytes 0xC3 and 0xFF (the 0xFF byte has a stuffed 0 inserted after six 1s), then EOP -> 16 bit_valid pulses; the stuffed bit is absent from the output; pkt_end asserted.
3. SYNC, then seven identical consecutive symbols (seven 1s) -> with USB_RX_STUFF_CHECK_EN: rx_error, rx_busy falls, no pkt_end. Without the macro: the 7th bit is dropped, and the packet completes as pkt_end if byte-aligned.
4. SYNC, 12 data bits, SE0, SE0, J -> 12 bit_valid pulses, rx_error, no pkt_end.
5. Bad SYNC K J K J K K K K -> no pkt_start, state IDLE. A following valid packet is received normally.
6. Assert reset for one cycle after 5 data bits -> all outputs 0 and no strobe. The next full 0xE1 packet yields 8 bits and pkt_end.
